// File: rtl/tf_pkg.sv
// Shared types and default sizing for the twiddle-factor preload path.
package tf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } tf_state_e;

  localparam int unsigned TF_D_WIDTH   = 64;
  localparam int unsigned TF_NUM_BANKS = 15;
  localparam int unsigned TF_DEPTH     = 16;

endpackage

// File: rtl/tf_cond_sub.sv
// Single conditional subtraction against the modulus, plus a flag for words that
// are still out of range afterwards (input was at least 2q).
module tf_cond_sub
  import tf_pkg::*;
#(
  parameter int unsigned W = TF_D_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] q,
  output logic [W-1:0] red,
  output logic         ovf
);

  // Unsigned compare-and-subtract; ovf looks at the reduced value.
  always_comb begin
    red = (a >= q) ? (a - q) : a;
    ovf = (red >= q);
  end

endmodule

// File: rtl/tf_preload_writer.sv
// Streams host twiddle words into the NTT twiddle banks, round-robin across banks,
// with one address step per full bank sweep. One start/done transaction per table.
module tf_preload_writer
  import tf_pkg::*;
#(
  parameter int unsigned D_WIDTH   = TF_D_WIDTH,
  parameter int unsigned NUM_BANKS = TF_NUM_BANKS,
  parameter int unsigned DEPTH     = TF_DEPTH,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [D_WIDTH-1:0]   modulus,
  input  logic                 s_valid,
  input  logic [D_WIDTH-1:0]   s_data,
  output logic                 s_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [D_WIDTH-1:0]   wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_range
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  tf_state_e            state;
  logic [D_WIDTH-1:0]   q_r;
  logic [BANK_W-1:0]    bank_cnt;
  logic [ADDR_W-1:0]    addr_cnt;
  logic [D_WIDTH-1:0]   red;
  logic                 ovf;
  logic                 accept;

  tf_cond_sub #(
    .W (D_WIDTH)
  ) u_cond_sub (
    .a   (s_data),
    .q   (q_r),
    .red (red),
    .ovf (ovf)
  );

  // Handshake and status decode straight from the registered state.
  always_comb begin
    s_ready = (state == LOAD);
    busy    = (state != IDLE);
    done    = (state == DONE);
    accept  = s_ready && s_valid;
  end

  // FSM, counters, write register stage and sticky range error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q_r       <= '0;
      bank_cnt  <= '0;
      addr_cnt  <= '0;
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_range <= 1'b0;
    end else begin
      wr_en <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q_r       <= modulus;
            bank_cnt  <= '0;
            addr_cnt  <= '0;
            err_range <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en   <= NUM_BANKS'(1) << bank_cnt;
            wr_addr <= addr_cnt;
            wr_data <= red;
            if (ovf) begin
              err_range <= 1'b1;
            end
            if (bank_cnt == BANK_LAST) begin
              bank_cnt <= '0;
              if (addr_cnt == ADDR_LAST) begin
                addr_cnt <= '0;
                state    <= DONE;
              end else begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
            end else begin
              bank_cnt <= bank_cnt + BANK_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tf_preload_writer.sv
// Self-checking bench for tf_preload_writer: table vectors plus a write scoreboard.
module tb_tf_preload_writer;

  localparam int NB = 15;
  localparam int DP = 16;
  localparam int TOTAL = NB * DP;

  logic          clk;
  logic          rst;
  logic          start;
  logic [63:0]   modulus;
  logic          s_valid;
  logic [63:0]   s_data;
  logic          s_ready;
  logic [NB-1:0] wr_en;
  logic [3:0]    wr_addr;
  logic [63:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err_range;

  tf_preload_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .modulus   (modulus),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err_range (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] en;
    logic [3:0]    addr;
    logic [63:0]   data;
    logic          done;
    logic          err;
  } exp_t;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side model of the writer.
  logic [63:0] m_q;
  int          m_n;
  int          m_bank;
  int          m_addr;
  logic        m_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] m_red(input logic [63:0] d, input logic [63:0] q);
    return (d >= q) ? d - q : d;
  endfunction

  task automatic m_begin(input logic [63:0] q);
    m_q = q; m_n = 0; m_bank = 0; m_addr = 0; m_err = 1'b0;
  endtask

  task automatic start_load(input logic [63:0] q);
    modulus = q;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s_ready_after_start", 128'(s_ready), 128'(1));
    check("busy_after_start", 128'(busy), 128'(1));
    m_begin(q);
  endtask

  // Drive one accepted word with explicit expected result.
  task automatic send_exp(input logic [63:0] d, input logic [63:0] ed, input logic eovf);
    exp_t e;
    e.en   = NB'(1) << m_bank;
    e.addr = 4'(m_addr);
    e.data = ed;
    m_err  = m_err | eovf;
    e.err  = m_err;
    e.done = (m_n == TOTAL - 1);
    sb.push_back(e);
    m_n++;
    if (m_bank == NB - 1) begin
      m_bank = 0;
      m_addr = (m_addr + 1) % DP;
    end else begin
      m_bank++;
    end
    s_valid = 1'b1;
    s_data  = d;
    check("s_ready_at_accept", 128'(s_ready), 128'(1));
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input int gap);
    logic [63:0] r;
    s_valid = 1'b0;
    repeat (gap) step();
    r = m_red(d, m_q);
    send_exp(d, r, r >= m_q);
  endtask

  // Compare every observed write against the scoreboard; done must coincide with a write.
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 128'(wr_en), 128'(0));
        end else begin
          me = sb.pop_front();
          check("write", 128'({wr_en, wr_addr, wr_data, done, err_range}),
                128'({me.en, me.addr, me.data, me.done, me.err}));
        end
      end else begin
        check("done_without_write", 128'(done), 128'(0));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    check({tag, "_wr_en"}, 128'(wr_en), 128'(0));
    check({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
    check({tag, "_wr_data"}, 128'(wr_data), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err_range"}, 128'(err_range), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit reached;
    vecs[0] = '{din: 64'd16, dout: 64'd16, ovf: 1'b0};
    vecs[1] = '{din: 64'd17, dout: 64'd0,  ovf: 1'b0};
    vecs[2] = '{din: 64'd30, dout: 64'd13, ovf: 1'b0};
    vecs[3] = '{din: 64'd40, dout: 64'd23, ovf: 1'b1};

    rst = 1'b1; start = 1'b0; modulus = '0; s_valid = 1'b0; s_data = '0;
    m_begin(64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Full load, word k = k.
    start_load(64'd12289);
    for (int k = 0; k < TOTAL; k++) send_word(64'(k), 0);
    check("done_on_last_write", 128'(done), 128'(1));
    check("busy_on_last_write", 128'(busy), 128'(1));
    step();
    check("busy_after_done", 128'(busy), 128'(0));
    check("done_after_done", 128'(done), 128'(0));

    // Reduction vectors, then fill out the table.
    start_load(64'd17);
    for (int i = 0; i < 4; i++) send_exp(vecs[i].din, vecs[i].dout, vecs[i].ovf);
    check("err_after_word40", 128'(err_range), 128'(1));
    for (int k = 4; k < TOTAL; k++) send_word(64'd0, 0);
    step(); step();

    // Random bubbles.
    start_load(64'd12289);
    for (int k = 0; k < TOTAL; k++) send_word(64'(k), int'($urandom_range(5, 0)));
    step(); step();

    // Ignored start and latched modulus.
    start_load(64'd1000);
    for (int k = 0; k < TOTAL; k++) begin
      if (k == 50) begin
        start = 1'b1; modulus = 64'd500;
        step();
        start = 1'b0;
      end
      if (k == 80) start = 1'b1;
      send_word(64'(k * 7), 0);
      start = 1'b0;
    end
    step(); step();

    // Reset mid-load after 100 words.
    start_load(64'd100);
    for (int k = 0; k < 100; k++) send_word(64'(k * 3), 0);
    step();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    check("sb_empty_at_reset", 128'(sb.size()), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Fresh load after reset: first word goes to bank 0, addr 0; word 250 flags err.
    start_load(64'd100);
    send_word(64'd250, 0);
    check("first_after_reset_en", 128'(wr_en), 128'(1));
    check("first_after_reset_addr", 128'(wr_addr), 128'(0));
    for (int k = 1; k < TOTAL; k++) send_word(64'(k % 100), 0);
    check("err_before_b2b", 128'(err_range), 128'(1));

    // Back-to-back: hold start until IDLE, sampled there.
    start = 1'b1;
    modulus = 64'd12289;
    reached = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!busy) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    check("b2b_idle_reached", 128'(reached), 128'(1));
    step();
    start = 1'b0;
    check("b2b_s_ready", 128'(s_ready), 128'(1));
    check("b2b_err_cleared", 128'(err_range), 128'(0));
    m_begin(64'd12289);
    for (int k = 0; k < TOTAL; k++) send_word(64'(k), 0);
    check("b2b_done", 128'(done), 128'(1));
    step(); step();

    check("sb_empty_at_end", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
